// File: rtl/frame_capture.sv
// Camera frame grabber: RGB565 byte stream -> 4-bit grayscale frame-BRAM writes.
// Build macro CAPTURE_GRAY_WEIGHTED_EN selects (R+2G+B)/4 luma instead of plain G[5:2].
module frame_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_strobe,
  input  logic [7:0]  cam_data,
  output logic        write_enable,
  output logic [18:0] write_address,
  output logic [3:0]  write_pixel,
  output logic        static_bram_rdy,
  output logic        frame_error
);

  localparam int LINE_W = $clog2(H_PIXELS) + 2;
  localparam int LCNT_W = $clog2(V_LINES) + 2;
  localparam logic [18:0]       FRAME_END = 19'(H_PIXELS * V_LINES);
  localparam logic [LINE_W-1:0] LINE_LEN  = LINE_W'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [18:0]       pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_pix_q, line_pix_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic              write_enable_q, write_enable_d;
  logic [18:0]       write_address_q, write_address_d;
  logic [3:0]        write_pixel_q, write_pixel_d;
  logic              rdy_q, rdy_d;
  logic              frame_error_q, frame_error_d;

  logic vsync_rise, vsync_fall, href_fall;
  logic [3:0] gray;

  assign vsync_rise = cam_vsync & ~vsync_q;
  assign vsync_fall = ~cam_vsync & vsync_q;
  assign href_fall  = ~cam_href & href_q;

  // Pixel word is {hi_byte_q, cam_data}: R=[15:11], G=[10:5], B=[4:0].
`ifdef CAPTURE_GRAY_WEIGHTED_EN
  logic [5:0] r6, g6, b6;
  assign r6   = {hi_byte_q[7:3], hi_byte_q[7]};
  assign g6   = {hi_byte_q[2:0], cam_data[7:5]};
  assign b6   = {cam_data[4:0], cam_data[4]};
  assign gray = 4'(({2'b00, r6} + {1'b0, g6, 1'b0} + {2'b00, b6}) >> 4);
`else
  assign gray = {hi_byte_q[2:0], cam_data[7]};
`endif

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d         = state_q;
    vsync_d         = cam_vsync;
    href_d          = cam_href;
    phase_d         = phase_q;
    hi_byte_d       = hi_byte_q;
    pix_cnt_d       = pix_cnt_q;
    line_pix_d      = line_pix_q;
    line_cnt_d      = line_cnt_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_pixel_d   = write_pixel_q;
    rdy_d           = rdy_q;
    frame_error_d   = frame_error_q;

    case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        if (capture_en && cam_vsync) state_d = WAIT_SOF;
      end

      WAIT_SOF: begin
        phase_d = 1'b0;
        if (vsync_fall) begin
          state_d       = CAPTURE;
          rdy_d         = 1'b0;
          pix_cnt_d     = '0;
          line_pix_d    = '0;
          line_cnt_d    = '0;
          frame_error_d = 1'b0;
        end
      end

      CAPTURE: begin
        if (!cam_href) begin
          phase_d = 1'b0;
        end else if (cam_strobe) begin
          if (!phase_q) begin
            hi_byte_d = cam_data;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (line_pix_q != '1) line_pix_d = line_pix_q + 1'b1;
            if (pix_cnt_q < FRAME_END) begin
              write_enable_d  = 1'b1;
              write_address_d = pix_cnt_q;
              write_pixel_d   = gray;
              pix_cnt_d       = pix_cnt_q + 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end
        end

        if (href_fall) begin
          if (line_pix_q != LINE_LEN) frame_error_d = 1'b1;
          if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
          line_pix_d = '0;
        end

        // A line-length error detected on this same edge must still block rdy.
        if (vsync_rise) begin
          state_d = DONE;
          if (pix_cnt_d == FRAME_END && !frame_error_d) rdy_d = 1'b1;
          else frame_error_d = 1'b1;
        end
      end

      DONE: begin
        phase_d = 1'b0;
        state_d = capture_en ? WAIT_SOF : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      vsync_q         <= 1'b0;
      href_q          <= 1'b0;
      phase_q         <= 1'b0;
      hi_byte_q       <= '0;
      pix_cnt_q       <= '0;
      line_pix_q      <= '0;
      line_cnt_q      <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_pixel_q   <= '0;
      rdy_q           <= 1'b0;
      frame_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      vsync_q         <= vsync_d;
      href_q          <= href_d;
      phase_q         <= phase_d;
      hi_byte_q       <= hi_byte_d;
      pix_cnt_q       <= pix_cnt_d;
      line_pix_q      <= line_pix_d;
      line_cnt_q      <= line_cnt_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_pixel_q   <= write_pixel_d;
      rdy_q           <= rdy_d;
      frame_error_q   <= frame_error_d;
    end
  end

  assign write_enable    = write_enable_q;
  assign write_address   = write_address_q;
  assign write_pixel     = write_pixel_q;
  assign static_bram_rdy = rdy_q;
  assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture on a reduced 16x6 frame with randomized byte gaps.
// Expected writes come from a queue filled by a frame-level model of the camera protocol.
module tb_frame_capture;

  localparam int W = 16;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_strobe = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        write_enable;
  logic [18:0] write_address;
  logic [3:0]  write_pixel;
  logic        static_bram_rdy;
  logic        frame_error;

  frame_capture #(.H_PIXELS(W), .V_LINES(H)) dut (
    .clk             (clk),
    .rst             (rst),
    .capture_en      (capture_en),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_strobe      (cam_strobe),
    .cam_data        (cam_data),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_pixel     (write_pixel),
    .static_bram_rdy (static_bram_rdy),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    int addr;
    int pix;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Frame-level model: capturing flag, pixels accepted, and the two status outputs.
  bit mdl_on = 1'b0;
  int mdl_cnt = 0;
  bit mdl_err = 1'b0;
  bit mdl_rdy = 1'b0;
  int frame_pix = 0;

  function automatic int gray_of(input int rgb);
`ifdef CAPTURE_GRAY_WEIGHTED_EN
    int r, g, b, r6, b6, y;
    r  = (rgb >> 11) & 31;
    g  = (rgb >> 5) & 63;
    b  = rgb & 31;
    r6 = r * 2 + r / 16;
    b6 = b * 2 + b / 16;
    y  = (r6 + 2 * g + b6) / 4;
    return y / 4;
`else
    return ((rgb >> 5) & 63) / 4;
`endif
  endfunction

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d pixel=%0d, required no write",
                 write_address, write_pixel);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_address !== 19'(mon_e.addr) || write_pixel !== 4'(mon_e.pix)) begin
          bad++;
          $display("FAIL write_data: got addr=%0d pixel=%0d, required addr=%0d pixel=%0d",
                   write_address, write_pixel, mon_e.addr, mon_e.pix);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) begin
      tick();
      cam_strobe = 1'b0;
      cam_data   = 8'($urandom);
    end
    tick();
    cam_strobe = 1'b1;
    cam_data   = b;
  endtask

  task automatic drive_line(input int npix, input int data, input bit odd, input int rst_at);
    logic [15:0] px;
    tick();
    cam_href   = 1'b1;
    cam_strobe = 1'b0;
    for (int p = 0; p < npix; p++) begin
      if (frame_pix == rst_at) begin
        tick();
        cam_strobe = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (write_enable !== 1'b0 || write_address !== 19'd0 || write_pixel !== 4'd0 ||
            static_bram_rdy !== 1'b0 || frame_error !== 1'b0) begin
          bad++;
          $display("FAIL midframe_reset: got we=%b addr=%0d pix=%0d rdy=%b err=%b, required all 0",
                   write_enable, write_address, write_pixel, static_bram_rdy, frame_error);
        end
        rst = 1'b0;
        mdl_on = 1'b0;
        mdl_err = 1'b0;
        mdl_rdy = 1'b0;
      end
      px = (data < 0) ? 16'($urandom) : 16'(data);
      send_byte(px[15:8]);
      send_byte(px[7:0]);
      if (mdl_on) begin
        if (mdl_cnt < N) begin
          exp_q.push_back('{addr: mdl_cnt, pix: gray_of(int'(px))});
          mdl_cnt++;
        end else begin
          mdl_err = 1'b1;
        end
      end
      frame_pix++;
    end
    if (odd) send_byte(8'($urandom));
    tick();
    cam_strobe = 1'b0;
    cam_href   = 1'b0;
    if (mdl_on && npix != W) mdl_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (frame_error !== mdl_err) begin
      bad++;
      $display("FAIL line_error: got frame_error=%b, required %b", frame_error, mdl_err);
    end
  endtask

  task automatic drive_frame(input int data, input int bad_line, input int bad_len,
                             input int odd_line, input int rst_at, input int drop_line);
    bit cap;
    tick();
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_strobe = 1'b0;
    cap = (capture_en === 1'b1);
    repeat (3) tick();
    tick();
    cam_vsync = 1'b0;
    if (cap) begin
      mdl_on  = 1'b1;
      mdl_cnt = 0;
      mdl_err = 1'b0;
      mdl_rdy = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (static_bram_rdy !== mdl_rdy || frame_error !== mdl_err) begin
      bad++;
      $display("FAIL sof_status: got rdy=%b err=%b, required rdy=%b err=%b",
               static_bram_rdy, frame_error, mdl_rdy, mdl_err);
    end
    frame_pix = 0;
    for (int l = 0; l < H; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      drive_line((l == bad_line) ? bad_len : W, data, l == odd_line, rst_at);
    end
    tick();
    cam_vsync = 1'b1;
    @(negedge clk);
    total++;
    if (static_bram_rdy !== mdl_rdy) begin
      bad++;
      $display("FAIL rdy_before_eof: got %b, required %b", static_bram_rdy, mdl_rdy);
    end
    if (mdl_on) begin
      mdl_rdy = (mdl_cnt == N) && !mdl_err;
      if (!mdl_rdy) mdl_err = 1'b1;
      mdl_on = 1'b0;
    end
    @(negedge clk);
    total++;
    if (static_bram_rdy !== mdl_rdy || frame_error !== mdl_err) begin
      bad++;
      $display("FAIL eof_status: got rdy=%b err=%b, required rdy=%b err=%b",
               static_bram_rdy, frame_error, mdl_rdy, mdl_err);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    capture_en = 1'b1;
    cam_vsync  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (write_enable !== 1'b0 || write_address !== 19'd0 || write_pixel !== 4'd0 ||
        static_bram_rdy !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got we=%b addr=%0d pix=%0d rdy=%b err=%b, required all 0",
               write_enable, write_address, write_pixel, static_bram_rdy, frame_error);
    end
    rst = 1'b0;
    mdl_on = 1'b0;
    mdl_err = 1'b0;
    mdl_rdy = 1'b0;
  endtask

  task automatic test_full_frame();
    capture_en = 1'b1;
    drive_frame(16'hFFFF, -1, 0, -1, -1, -1);
  endtask

  task automatic test_green();
    drive_frame(16'h07E0, -1, 0, -1, -1, -1);
  endtask

  task automatic test_random_frames();
    repeat (2) drive_frame(-1, -1, 0, -1, -1, -1);
  endtask

  task automatic test_short_line();
    drive_frame(-1, 3, W - 1, -1, -1, -1);
  endtask

  task automatic test_odd_bytes();
    drive_frame(-1, -1, 0, 2, -1, -1);
  endtask

  task automatic test_overflow();
    drive_frame(-1, H - 1, W + 2, -1, -1, -1);
  endtask

  task automatic test_midframe_enable();
    test_reset();
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    drive_line(W, -1, 1'b0, -1);
    capture_en = 1'b1;
    drive_line(W, -1, 1'b0, -1);
    @(negedge clk);
    total++;
    if (static_bram_rdy !== 1'b0) begin
      bad++;
      $display("FAIL midframe_enable_rdy: got %b, required 0", static_bram_rdy);
    end
    drive_frame(-1, -1, 0, -1, -1, -1);
  endtask

  task automatic test_reset_midframe();
    capture_en = 1'b1;
    drive_frame(-1, -1, 0, -1, 20, -1);
    drive_frame(-1, -1, 0, -1, -1, -1);
  endtask

  task automatic test_enable_drop();
    capture_en = 1'b1;
    drive_frame(-1, -1, 0, -1, -1, 3);
    drive_frame(-1, -1, 0, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_green();
    test_random_frames();
    test_short_line();
    test_odd_bytes();
    test_overflow();
    test_midframe_enable();
    test_reset_midframe();
    test_enable_drop();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Timing: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 capture_en  input  1  level; high = capture successive frames.
REQ-005 cam_vsync  input  1  camera vsync, already synchronized to clk; high = vertical blanking.
REQ-006 cam_href  input  1  camera line-valid, synchronized to clk.
REQ-007 cam_strobe  input  1  one-cycle pulse per valid cam_data byte.
REQ-008 cam_data  input  8  camera byte, RGB565, high byte first.
REQ-009 write_enable  output  1  frame-BRAM write strobe.
REQ-010 write_address  output  19  frame-BRAM address, 0..307199.
REQ-011 write_pixel  output  4  grayscale pixel.
REQ-012 static_bram_rdy  output  1  high = complete frame in BRAM; consumer detects rising edge.
REQ-013 frame_error  output  1  sticky: last frame had a wrong line length or pixel count.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT_SOF, CAPTURE and DONE.
REQ-015 IDLE->WAIT_SOF when capture_en=1 and cam_vsync=1; frame capture never starts mid-frame.
REQ-016 WAIT_SOF->CAPTURE on the cam_vsync falling edge; on that cycle static_bram_rdy->0, the pixel counter and line counter clear to 0, and frame_error clears.
REQ-017 In CAPTURE, the byte phase toggles on each cam_strobe while cam_href=1; it returns to high-byte phase whenever cam_href=0.
REQ-018 On a low-phase strobe, one pixel is formed from {high,low} bytes: R=[15:11], G=[10:5], B=[4:0].
REQ-019 Write latency: write_enable is high for exactly one cycle, the cycle after the low-byte strobe, with write_address equal to the pixel counter; the counter then increments.
REQ-020 Writes are suppressed once the counter reaches 307200; extra pixels set frame_error and never wrap to address 0.
REQ-021 On each cam_href falling edge in CAPTURE, if the line's pixel count is not 640, frame_error is set; the line counter increments regardless.
REQ-022 An odd byte count in a line discards the dangling high byte.
REQ-023 CAPTURE->DONE on the cam_vsync rising edge; static_bram_rdy->1 only if the pixel counter is 307200 and no error occurred; otherwise it stays 0 and frame_error=1.
REQ-024 DONE->WAIT_SOF if capture_en=1, else ->IDLE; static_bram_rdy holds until the next SOF.
REQ-025 capture_en deasserted during CAPTURE SHALL NOT abort; the current frame completes.
REQ-026 cam_strobe with cam_href=0, or outside CAPTURE, is ignored.
REQ-027 write_enable, write_address and write_pixel SHALL be registered outputs.

Reset
REQ-028 rst SHALL force state=IDLE, write_enable=0, write_address=0, write_pixel=0, static_bram_rdy=0, frame_error=0, with counters and byte phase cleared.
REQ-029 rst mid-frame SHALL discard the partial frame; capture resumes only at the next full vsync high->low.

Configuration
REQ-030 The macro is CAPTURE_GRAY_WEIGHTED_EN.
REQ-031 With CAPTURE_GRAY_WEIGHTED_EN defined, the pixel is computed as follows:
  - r6={R,R[4]} and b6={B,B[4]};
  - y=(r6+2*G+b6)>>2, 6 bits;
  - write_pixel=y[5:2].
REQ-032 Without CAPTURE_GRAY_WEIGHTED_EN, write_pixel=G[5:2]; latency is identical in both builds.

Verification
REQ-033 Full 640x480 frame, pixel bytes 0xFFFF, capture_en=1 -> 307200 writes, addresses 0..307199 in order, write_pixel=15 every write, rdy rises 1 cycle after vsync rises, frame_error=0.
REQ-034 Pixel bytes 0x07E0 (pure green) -> write_pixel=15 without the macro; write_pixel=7 with the macro (y=31).
REQ-035 Line 10 carries 639 pixels -> frame_error=1 at that href fall; rdy stays 0 at frame end.
REQ-036 capture_en raised mid-frame (vsync=0) -> no writes until the next vsync high->low, then a normal capture.
REQ-037 rst asserted at pixel 1000 -> outputs go to reset values the next cycle; the next full frame starts at address 0 and sets rdy=1.
REQ-038 capture_en dropped at line 200 -> the frame completes with 307200 writes, rdy=1, and the FSM returns to IDLE; the following frame produces no writes.
